// File: rtl/vram_pkg.sv
// Shared widths and arbiter state encoding for the video RAM arbiter.
package vram_pkg;

  localparam int unsigned VRAM_ADDR_WIDTH = 11;
  localparam int unsigned VRAM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUED = 2'd1,
    ACK    = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Shares the single-port video RAM between display fetches (absolute priority) and CPU req/ack accesses.
// Optional feature macro: VRAM_ARB_BLANK_ONLY_EN restricts CPU grants to blanking (vid_active=0).
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = VRAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  input  logic                  vid_active,
  output logic                  vid_valid,
  output logic [DATA_WIDTH-1:0] vid_data,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  arb_state_t state;
  arb_state_t state_next;
  logic       cpu_allowed_c;
  logic       cpu_grant_c;
  logic       ack_next;
  logic       capture_c;
  logic       op_read;

`ifdef VRAM_ARB_BLANK_ONLY_EN
  // CPU touches the RAM only outside visible lines, so the display never sees snow.
  assign cpu_allowed_c = !vid_active;
`else
  logic unused_vid_active;
  assign unused_vid_active = vid_active;
  assign cpu_allowed_c     = 1'b1;
`endif

  // Video always wins the port; the CPU only gets a free IDLE cycle, and never while in reset.
  assign cpu_grant_c = !reset && !vid_req && (state == IDLE) && cpu_req && cpu_allowed_c;

  assign ram_addr  = vid_req ? vid_addr : cpu_addr;
  assign ram_we    = cpu_grant_c && cpu_we;
  assign ram_wdata = cpu_wdata;
  assign vid_data  = ram_rdata;

  // Next-state and registered-output decode.
  always_comb begin
    state_next = state;
    ack_next   = 1'b0;
    capture_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_grant_c) state_next = ISSUED;
      end
      ISSUED: begin
        ack_next   = 1'b1;
        capture_c  = op_read;
        state_next = ACK;
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The CPU byte is captured in ISSUED; a video fetch issued that same cycle returns one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      vid_valid <= 1'b0;
      op_read   <= 1'b0;
    end else begin
      state     <= state_next;
      cpu_ack   <= ack_next;
      vid_valid <= vid_req;
      if (cpu_grant_c) op_read <= !cpu_we;
      if (capture_c) cpu_rdata <= ram_rdata;
    end
  end

  a_we_not_with_video: assert property (@(posedge clk) disable iff (reset) ram_we |-> !vid_req);
  a_ack_single_pulse:  assert property (@(posedge clk) disable iff (reset) cpu_ack |=> !cpu_ack);

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboarded random bench for vram_arbiter with a RAM model and a cycle-schedule reference model.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int unsigned AW = VRAM_ADDR_WIDTH;
  localparam int unsigned DW = VRAM_DATA_WIDTH;
  localparam int NCYC     = 8192;
  localparam int RST_AT   = 141;
  localparam int WAIT_MAX = 300;
  localparam int RAND_END = 3200;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_active = 1'b0;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_active(vid_active),
    .vid_valid(vid_valid), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM with one cycle of read latency.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {int cyc; logic [DW-1:0] data;} exp_t;
  typedef struct {int cyc; logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  typedef struct {int at; bit we; logic [AW-1:0] addr; logic [DW-1:0] data; bit abort;} op_t;

  logic [DW-1:0] model_mem [2**AW];
  bit            vid_s [NCYC];
  logic [AW-1:0] vaddr_s [NCYC];
  bit            act_s [NCYC];

  exp_t vq[$];
  exp_t cq[$];
  wr_t  wq[$];
  wr_t  pend_wr[$];
  op_t  ops[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 1'b0;
  logic [DW-1:0] last_rdata = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  // A cycle is usable by the CPU when no display fetch claims it (and, in blank-only builds, outside visible lines).
  function automatic bit cpu_slot(input int c);
    if (c >= NCYC) return 1'b1;
`ifdef VRAM_ARB_BLANK_ONLY_EN
    return !vid_s[c] && !act_s[c];
`else
    return !vid_s[c];
`endif
  endfunction

  task automatic add_op(input int at, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit ab);
    op_t o;
    o.at = at; o.we = we; o.addr = a; o.data = d; o.abort = ab;
    ops.push_back(o);
  endtask

  // Output monitor: every valid/ack/write strobe is matched against the oldest expectation.
  exp_t mon_e;
  wr_t  mon_w;
  always @(negedge clk) begin
    if (started && !reset) begin
      if (vid_req) check("ram_addr_video", 32'(ram_addr), 32'(vid_addr));
      if (vid_valid) begin
        if (vq.size() == 0) check("vid_valid_spurious", 32'(1), 32'(0));
        else begin
          mon_e = vq.pop_front();
          check("vid_valid_cycle", 32'(cyc), 32'(mon_e.cyc));
          check("vid_data", 32'(vid_data), 32'(mon_e.data));
        end
      end else if (vq.size() > 0 && vq[0].cyc <= cyc) begin
        check("vid_valid_missing", 32'(0), 32'(1));
        void'(vq.pop_front());
      end
      if (cpu_ack) begin
        if (cq.size() == 0) check("cpu_ack_spurious", 32'(1), 32'(0));
        else begin
          mon_e = cq.pop_front();
          check("cpu_ack_cycle", 32'(cyc), 32'(mon_e.cyc));
          check("cpu_rdata", 32'(cpu_rdata), 32'(mon_e.data));
        end
      end else if (cq.size() > 0 && cq[0].cyc <= cyc) begin
        check("cpu_ack_missing", 32'(0), 32'(1));
        void'(cq.pop_front());
      end
      if (ram_we) begin
        if (wq.size() == 0) check("ram_we_spurious", 32'(1), 32'(0));
        else begin
          mon_w = wq.pop_front();
          check("ram_we_cycle", 32'(cyc), 32'(mon_w.cyc));
          check("ram_we_addr", 32'(ram_addr), 32'(mon_w.addr));
          check("ram_we_data", 32'(ram_wdata), 32'(mon_w.data));
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        check("ram_we_missing", 32'(0), 32'(1));
        void'(wq.pop_front());
      end
    end
  end

  bit  busy = 1'b0;
  int  t0 = 0;
  int  next_ok = 0;
  int  g;
  int  seg;
  bit  act;
  int  at;
  op_t op;
  wr_t w;
  exp_t e;

  initial begin
    // Memory image: generic pattern with the bytes the directed scenarios rely on.
    for (int i = 0; i < 2**AW; i++) model_mem[i] = 8'((i * 7 + 3) & 8'hFF);
    for (int i = 0; i < 8; i++) model_mem[i] = 8'(i);
    model_mem[11'h028] = 8'h38;
    model_mem[11'h050] = 8'h6C;
    model_mem[11'h051] = 8'hA5;
    model_mem[11'h7FF] = 8'hC3;
    for (int i = 0; i < 2**AW; i++) mem[i] = model_mem[i];

    // Display fetch and visible-line schedule.
    for (int c = 0; c < NCYC; c++) begin vid_s[c] = 1'b0; vaddr_s[c] = '0; act_s[c] = 1'b0; end
    for (int i = 0; i < 8; i++) begin vid_s[8*i] = 1'b1; vaddr_s[8*i] = AW'(i); end
    vid_s[100] = 1'b1; vaddr_s[100] = 11'h028;
    vid_s[121] = 1'b1; vaddr_s[121] = 11'h051;
    for (int c = 160; c < 180; c++) begin vid_s[c] = 1'b1; vaddr_s[c] = AW'($urandom); end
    for (int c = 190; c < 200; c++) act_s[c] = 1'b1;
    act = 1'b0; seg = 10;
    for (int c = 200; c < RAND_END; c++) begin
      vid_s[c] = ($urandom_range(0, 3) == 0);
      vaddr_s[c] = AW'($urandom);
      act_s[c] = act;
      seg--;
      if (seg == 0) begin act = !act; seg = $urandom_range(4, 30); end
    end

    // CPU operations: directed scenarios followed by random traffic.
    add_op(70, 1'b1, 11'h123, 8'h5A, 1'b0);
    add_op(75, 1'b0, 11'h123, 8'h00, 1'b0);
    add_op(100, 1'b0, 11'h7FF, 8'h00, 1'b0);
    add_op(120, 1'b0, 11'h050, 8'h00, 1'b0);
    add_op(140, 1'b0, 11'h200, 8'h00, 1'b1);
    add_op(146, 1'b0, 11'h200, 8'h00, 1'b0);
    add_op(162, 1'b0, 11'h3AB, 8'h00, 1'b0);
    add_op(190, 1'b0, 11'h7FF, 8'h00, 1'b0);
    at = 205;
    while (at < RAND_END - 50) begin
      add_op(at, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? AW'(11'h100 + 11'($urandom_range(0, 15))) : AW'($urandom),
             DW'($urandom), 1'b0);
      at += $urandom_range(1, 12);
    end

    // Reset phase: request a write throughout to show the grant is held off.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h100; cpu_wdata = 8'hEE;
    vid_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cpu_ack", 32'(cpu_ack), 32'(0));
    check("reset_cpu_rdata", 32'(cpu_rdata), 32'(0));
    check("reset_vid_valid", 32'(vid_valid), 32'(0));
    check("reset_ram_we", 32'(ram_we), 32'(0));
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
    reset = 1'b0;
    cyc = 0;
    started = 1'b1;

    while (cyc < NCYC - 16 && !(cyc > RAND_END + 20 && ops.size() == 0 && !busy)) begin
      while (pend_wr.size() > 0 && pend_wr[0].cyc < cyc) begin
        w = pend_wr.pop_front();
        model_mem[w.addr] = w.data;
      end

      if (busy) begin
        if (cpu_ack) begin
          busy = 1'b0; cpu_req = 1'b0; next_ok = cyc + 1;
        end else if (cyc - t0 > WAIT_MAX) begin
          check("cpu_wait_timeout", 32'(0), 32'(1));
          busy = 1'b0; cpu_req = 1'b0; next_ok = cyc + 1;
        end
      end

      if (cyc == RST_AT) begin
        reset = 1'b1; cpu_req = 1'b0; busy = 1'b0; last_rdata = '0;
      end
      if (cyc == RST_AT + 1) begin
        check("midreset_cpu_ack", 32'(cpu_ack), 32'(0));
        check("midreset_cpu_rdata", 32'(cpu_rdata), 32'(0));
        check("midreset_vid_valid", 32'(vid_valid), 32'(0));
        check("midreset_ram_we", 32'(ram_we), 32'(0));
      end
      if (cyc == RST_AT + 2) reset = 1'b0;

      if (!busy && !reset && ops.size() > 0 && cyc >= ops[0].at && cyc >= next_ok) begin
        op = ops.pop_front();
        g = cyc;
        while (g < NCYC && !cpu_slot(g)) g++;
        cpu_req = 1'b1; cpu_we = op.we; cpu_addr = op.addr; cpu_wdata = op.data;
        busy = 1'b1; t0 = cyc;
        if (!op.abort) begin
          if (op.we) begin
            w.cyc = g; w.addr = op.addr; w.data = op.data;
            pend_wr.push_back(w);
            wq.push_back(w);
          end else begin
            last_rdata = model_mem[op.addr];
          end
          e.cyc = g + 2; e.data = last_rdata;
          cq.push_back(e);
        end
      end

      vid_req = vid_s[cyc];
      vid_addr = vaddr_s[cyc];
      vid_active = act_s[cyc];
      if (vid_s[cyc]) begin
        e.cyc = cyc + 1; e.data = model_mem[vaddr_s[cyc]];
        vq.push_back(e);
      end

      @(posedge clk); #1;
      cyc++;
    end

    check("drain_ops", 32'(ops.size()), 32'(0));
    check("drain_video", 32'(vq.size()), 32'(0));
    check("drain_cpu", 32'(cq.size()), 32'(0));
    check("drain_writes", 32'(wq.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
